// File: rtl/dma_rd_burst_splitter.sv
// Read DMA burst splitter: turns one (addr, len) descriptor into AXI4 INCR read
// bursts bounded by MAX_BURST_BEATS and 4 KB pages, and streams R data out as AXI-Stream.
module dma_rd_burst_splitter #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [AXI_LEN_WIDTH-1:0]  s_desc_len,
  input  logic                      s_desc_valid,
  output logic                      s_desc_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      st_valid,
  output logic [3:0]                st_error
);

  localparam int BPB     = AXI_DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int BW      = AXI_LEN_WIDTH - LOG_BPB;
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, STATUS} state_t;

  state_t                    state, state_nxt;
  logic                      rdy_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]             rem_ar_q, rem_r_q;
  logic [7:0]                arlen_q;
  logic [OW-1:0]             outst_q;
  logic                      err_q;
  logic [1:0]                chk_code_q;

  logic                      r_active, ar_hs, r_hs, desc_hs;
  logic                      misaligned, zero_len;
  logic [BW-1:0]             desc_beats, rem_ar_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_nxt;
  logic [8:0]                nb_cur;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page end.
  function automatic logic [8:0] calc_nb(input logic [AXI_ADDR_WIDTH-1:0] a,
                                         input logic [BW-1:0] rem);
    logic [12:0]   room;
    logic [BW-1:0] n;
    room = 13'h1000 - {1'b0, a[11:0]};
    n    = rem;
    if (n > BW'(MAX_BURST_BEATS)) n = BW'(MAX_BURST_BEATS);
    if (n > BW'(room >> LOG_BPB)) n = BW'(room >> LOG_BPB);
    return n[8:0];
  endfunction

  assign desc_beats = BW'(s_desc_len >> LOG_BPB);
  assign misaligned = ((s_desc_addr & AXI_ADDR_WIDTH'(BPB - 1)) != '0) ||
                      ((s_desc_len & AXI_LEN_WIDTH'(BPB - 1)) != '0);
  assign zero_len   = (s_desc_len == '0);
  assign desc_hs    = s_desc_valid && s_desc_ready;

  assign nb_cur     = {1'b0, arlen_q} + 9'd1;
  assign addr_nxt   = addr_q + (AXI_ADDR_WIDTH'(nb_cur) << LOG_BPB);
  assign rem_ar_nxt = rem_ar_q - BW'(nb_cur);

  assign m_arvalid  = (state == ISSUE) && (outst_q < OW'(MAX_OUTSTANDING));
  assign m_araddr   = addr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = 3'(LOG_BPB);
  assign m_arburst  = 2'b01;
  assign ar_hs      = m_arvalid && m_arready;

  // R channel is a straight wire to the stream while a descriptor is in flight.
  assign r_active      = (state == ISSUE) || (state == DRAIN);
  assign m_rready      = r_active && m_axis_tready;
  assign m_axis_tvalid = r_active && m_rvalid;
  assign m_axis_tdata  = r_active ? m_rdata : '0;
  assign m_axis_tlast  = r_active && m_rvalid && (rem_r_q == BW'(1));
  assign r_hs          = m_rvalid && m_rready;

  assign s_desc_ready  = rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    st_valid  = 1'b0;
    st_error  = 4'd0;
    case (state)
      IDLE:   if (s_desc_valid && rdy_q) state_nxt = (misaligned || zero_len) ? STATUS : ISSUE;
      ISSUE:  if (ar_hs && (rem_ar_q == BW'(nb_cur))) state_nxt = DRAIN;
      DRAIN:  if ((rem_r_q == '0) || (r_hs && (rem_r_q == BW'(1)))) state_nxt = STATUS;
      STATUS: begin
        st_valid  = 1'b1;
        st_error  = (chk_code_q != 2'd0) ? {2'b00, chk_code_q} : (err_q ? 4'd3 : 4'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_ar_q   <= '0;
      rem_r_q    <= '0;
      arlen_q    <= '0;
      err_q      <= 1'b0;
      chk_code_q <= 2'd0;
    end else if (desc_hs) begin
      addr_q     <= s_desc_addr;
      rem_ar_q   <= desc_beats;
      rem_r_q    <= desc_beats;
      arlen_q    <= 8'(calc_nb(s_desc_addr, desc_beats) - 9'd1);
      err_q      <= 1'b0;
      chk_code_q <= misaligned ? 2'd1 : (zero_len ? 2'd2 : 2'd0);
    end else begin
      // arlen for the following burst is precomputed so it is a clean register output.
      if (ar_hs) begin
        addr_q   <= addr_nxt;
        rem_ar_q <= rem_ar_nxt;
        arlen_q  <= 8'(calc_nb(addr_nxt, rem_ar_nxt) - 9'd1);
      end
      if (r_hs) begin
        rem_r_q <= rem_r_q - BW'(1);
        if (m_rresp != 2'b00) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      case ({ar_hs, r_hs && m_rlast})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: doc/dma_rd_burst_splitter.md
Name: dma_rd_burst_splitter

Overview:
- Read-side DMA engine stage that consumes one read descriptor at a time (byte address + byte length) from the pixels or weights descriptor channel of the DMA controller.
- Splits each descriptor into AXI4 INCR read bursts that respect both the maximum burst size and 4 KB boundaries.
- Streams the returned R data out as AXI-Stream with tlast on the final beat of the descriptor.
- Emits a one-cycle completion/status pulse per descriptor.

Parameters:
AXI_ADDR_WIDTH, 32, address width of descriptor and AR channel
AXI_DATA_WIDTH, 128, R / AXIS data width; BPB = AXI_DATA_WIDTH/8 bytes per beat (power of 2)
AXI_LEN_WIDTH, 32, descriptor byte-length width
MAX_BURST_BEATS, 16, max beats per AR burst (power of 2, 1..256)
MAX_OUTSTANDING, 4, max AR bursts issued whose rlast has not yet been received

Ports:
clk  in  1  clock
rst  in  1  reset
s_desc_addr  in  AXI_ADDR_WIDTH  descriptor start byte address
s_desc_len  in  AXI_LEN_WIDTH  descriptor length in bytes
s_desc_valid  in  1  descriptor valid
s_desc_ready  out  1  descriptor accepted when valid&&ready
m_araddr  out  AXI_ADDR_WIDTH  burst address
m_arlen  out  8  beats-1
m_arsize  out  3  constant log2(BPB)
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_rdata  in  AXI_DATA_WIDTH  read data
m_rresp  in  2  read response
m_rlast  in  1  last beat of burst
m_rvalid  in  1  R valid
m_rready  out  1  R ready
m_axis_tdata  out  AXI_DATA_WIDTH  output data
m_axis_tlast  out  1  final beat of descriptor
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
st_valid  out  1  one-cycle status pulse per descriptor
st_error  out  4  status code, valid with st_valid

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except m_arsize and m_arburst, which are constants. All counters clear, state IDLE.
- A reset asserted mid-transfer abandons outstanding bursts; the interconnect must be reset together with this block.
- States:
  - IDLE: s_desc_ready=1. On accept, latch addr, beats = len/BPB, and check the descriptor:
    - addr%BPB != 0 or len%BPB != 0 -> STATUS with code 1.
    - len == 0 -> STATUS with code 2.
    - otherwise -> ISSUE.
  - ISSUE: drive AR. Burst beats nb = min(remaining_ar_beats, MAX_BURST_BEATS, (4096 - addr[11:0])/BPB). m_arlen = nb-1, registered and stable while m_arvalid && !m_arready.
    - m_arvalid is asserted only while outstanding < MAX_OUTSTANDING.
    - On each AR handshake: addr += nb*BPB, remaining_ar_beats -= nb, outstanding++.
    - When remaining_ar_beats reaches 0 -> DRAIN.
  - DRAIN: wait until remaining_r_beats == 0, then go to STATUS.
  - STATUS: st_valid=1 for exactly one cycle with code; next cycle IDLE.
- R path (active in ISSUE and DRAIN):
  - Combinational pass-through: m_axis_tdata=m_rdata, m_axis_tvalid=m_rvalid, m_rready=m_axis_tready. No buffering; zero-cycle latency.
  - On each beat handshake, remaining_r_beats decrements.
  - m_axis_tlast = m_rvalid && remaining_r_beats == 1.
  - outstanding-- on a beat handshake with m_rlast. A simultaneous AR handshake and rlast leaves outstanding unchanged.
- Error handling: m_rresp != 0 on any beat sets a sticky error flag; the data is still forwarded and counting continues. Final code = 3 if the flag is set, else 0. The flag clears on the next descriptor accept.
- Status codes: 0 ok, 1 misaligned, 2 zero length, 3 AXI response error.
- The last beat handshake in DRAIN gives st_valid on the next cycle. Bursts already issued may return R while ISSUE is still active.
- Width rules:
  - Beat counters are AXI_LEN_WIDTH - log2(BPB) bits.
  - Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH, with no overflow check.
  - The 4 KB computation uses only addr[11:0].

Test Plan:
- BPB=16, MAX_BURST=16: desc addr 0x1000, len 512 -> ARs (0x1000, arlen 15), (0x1100, arlen 15); 32 AXIS beats, tlast only on beat 32; st_valid with code 0 one cycle after the last beat.
- 4 KB crossing: addr 0x0FC0, len 256 -> ARs (0x0FC0, arlen 3), (0x1000, arlen 11); 16 beats delivered in order.
- Outstanding limit: arready=1, rvalid held 0, addr 0, len 2048 -> exactly 4 AR handshakes, then m_arvalid=0. After one burst of 16 beats with rlast, exactly one more AR is issued.
- Misaligned: addr 0x1004, len 64 -> no m_arvalid; st_valid=1, st_error=1 on the cycle after accept; s_desc_ready returns to 1 the following cycle. Likewise len 0 -> st_error=2.
- rresp=2'b10 on beat 5 of a 16-beat descriptor -> all 16 beats forwarded, st_error=3.
- Backpressure: toggle m_axis_tready 1/0 every cycle on a 64-beat descriptor -> m_rready mirrors tready, no beat is lost or duplicated, tlast on beat 64.
- Reset asserted mid-DRAIN -> m_arvalid, m_axis_tvalid and st_valid go to 0 immediately (asynchronously); s_desc_ready=1 after release.
